// File: rtl/cdc_clear_sequencer.sv
// One clock-domain half of a two-domain clear/isolate sequencer for clearable CDCs.
// The initiator drives the peer through ISOLATE -> CLEAR -> POST_CLEAR and the responder serves the peer's requests.
`timescale 1ns / 100ps

module cdc_clear_sequencer #(
    parameter int unsigned SYNC_STAGES          = 2,
    parameter bit          CLEAR_ON_ASYNC_RESET = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    output logic       clear_pending_o,
    output logic       isolate_o,
    input  logic       isolate_ack_i,
    output logic       clear_o,
    input  logic       clear_ack_i,
    output logic       async_req_o,
    output logic [1:0] async_phase_o,
    input  logic       async_ack_i,
    input  logic       async_req_i,
    input  logic [1:0] async_phase_i,
    output logic       async_ack_o
);

    localparam logic [1:0] PH_NONE    = 2'b00;
    localparam logic [1:0] PH_ISOLATE = 2'b01;
    localparam logic [1:0] PH_CLEAR   = 2'b10;
    localparam logic [1:0] PH_POST    = 2'b11;

    typedef enum logic [2:0] {
        INI_IDLE, INI_ISO, INI_CLR, INI_POST, INI_DONE
    } ini_state_e;

    typedef enum logic [2:0] {
        RSP_IDLE, RSP_ISO, RSP_CLR, RSP_POST, RSP_DROP
    } rsp_state_e;

    generate
        if (SYNC_STAGES < 2) begin : g_sync_stages_check
            $error("cdc_clear_sequencer: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] req_sync_q;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   req_dly_q;
    logic                   ack_dly_q;
    logic                   req_synced;
    logic                   ack_synced;
    logic                   req_toggle;
    logic                   ack_toggle;
    logic                   ack_got;

    ini_state_e ini_state_q, ini_state_d;
    rsp_state_e rsp_state_q, rsp_state_d;
    logic       ini_iso_q, ini_iso_d;
    logic       ini_clr_q, ini_clr_d;
    logic       ack_seen_q, ack_seen_d;
    logic       pending_q, pending_d;
    logic       boot_q;
    logic       rsp_iso_q, rsp_iso_d;
    logic       rsp_clr_q, rsp_clr_d;
    logic       req_d;
    logic [1:0] phase_d;
    logic       ack_d;

    assign req_synced = req_sync_q[SYNC_STAGES-1];
    assign ack_synced = ack_sync_q[SYNC_STAGES-1];
    // The request delay flop only follows while the responder is idle, so a toggle that
    // lands during a busy responder stays pending instead of being lost.
    assign req_toggle = (req_synced ^ req_dly_q) && (rsp_state_q == RSP_IDLE);
    assign ack_toggle = ack_synced ^ ack_dly_q;
    assign ack_got    = ack_seen_q | ack_toggle;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
        ini_state_d = ini_state_q;
        ini_iso_d   = ini_iso_q;
        ini_clr_d   = ini_clr_q;
        ack_seen_d  = ack_seen_q;
        pending_d   = pending_q;
        req_d       = async_req_o;
        phase_d     = async_phase_o;
        rsp_state_d = rsp_state_q;
        rsp_iso_d   = rsp_iso_q;
        rsp_clr_d   = rsp_clr_q;
        ack_d       = async_ack_o;

        case (ini_state_q)
            INI_IDLE: begin
                if (clear_i || pending_q || boot_q) begin
                    ini_state_d = INI_ISO;
                    ini_iso_d   = 1'b1;
                    phase_d     = PH_ISOLATE;
                    req_d       = ~async_req_o;
                    ack_seen_d  = 1'b0;
                    pending_d   = 1'b0;
                end
            end
            INI_ISO: begin
                ack_seen_d = ack_got;
                if (ack_got && isolate_ack_i) begin
                    ini_state_d = INI_CLR;
                    ini_clr_d   = 1'b1;
                    phase_d     = PH_CLEAR;
                    req_d       = ~async_req_o;
                    ack_seen_d  = 1'b0;
                end
            end
            INI_CLR: begin
                ack_seen_d = ack_got;
                if (ack_got && clear_ack_i) begin
                    ini_state_d = INI_POST;
                    ini_clr_d   = 1'b0;
                    phase_d     = PH_POST;
                    req_d       = ~async_req_o;
                    ack_seen_d  = 1'b0;
                end
            end
            INI_POST: begin
                if (ack_toggle) ini_state_d = INI_DONE;
            end
            INI_DONE: begin
                ini_state_d = INI_IDLE;
                ini_iso_d   = 1'b0;
            end
            default: ini_state_d = INI_IDLE;
        endcase

        if ((ini_state_q != INI_IDLE) && clear_i) pending_d = 1'b1;

        case (rsp_state_q)
            RSP_IDLE: begin
                if (req_toggle) begin
                    case (async_phase_i)
                        PH_ISOLATE: begin
                            rsp_iso_d   = 1'b1;
                            rsp_state_d = RSP_ISO;
                        end
                        PH_CLEAR: begin
                            rsp_clr_d   = 1'b1;
                            rsp_state_d = RSP_CLR;
                        end
                        PH_POST: begin
                            rsp_clr_d   = 1'b0;
                            rsp_state_d = RSP_POST;
                        end
                        default: ack_d = ~async_ack_o;
                    endcase
                end
            end
            RSP_ISO: begin
                if (isolate_ack_i) begin
                    ack_d       = ~async_ack_o;
                    rsp_state_d = RSP_IDLE;
                end
            end
            RSP_CLR: begin
                if (clear_ack_i) begin
                    ack_d       = ~async_ack_o;
                    rsp_state_d = RSP_IDLE;
                end
            end
            RSP_POST: begin
                ack_d       = ~async_ack_o;
                rsp_state_d = RSP_DROP;
            end
            RSP_DROP: begin
                rsp_iso_d   = 1'b0;
                rsp_state_d = RSP_IDLE;
            end
            default: rsp_state_d = RSP_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so every pin, including the async ones, comes straight from a flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_sync_q      <= '0;
            ack_sync_q      <= '0;
            req_dly_q       <= 1'b0;
            ack_dly_q       <= 1'b0;
            ini_state_q     <= INI_IDLE;
            rsp_state_q     <= RSP_IDLE;
            ini_iso_q       <= 1'b0;
            ini_clr_q       <= 1'b0;
            ack_seen_q      <= 1'b0;
            pending_q       <= 1'b0;
            boot_q          <= CLEAR_ON_ASYNC_RESET;
            rsp_iso_q       <= 1'b0;
            rsp_clr_q       <= 1'b0;
            async_req_o     <= 1'b0;
            async_phase_o   <= PH_NONE;
            async_ack_o     <= 1'b0;
            isolate_o       <= 1'b0;
            clear_o         <= 1'b0;
            clear_pending_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, like real hardware.
            req_sync_q      <= {req_sync_q[SYNC_STAGES-2:0], async_req_i};
            ack_sync_q      <= {ack_sync_q[SYNC_STAGES-2:0], async_ack_i};
            req_dly_q       <= (rsp_state_q == RSP_IDLE) ? req_synced : req_dly_q;
            ack_dly_q       <= ack_synced;
            ini_state_q     <= ini_state_d;
            rsp_state_q     <= rsp_state_d;
            ini_iso_q       <= ini_iso_d;
            ini_clr_q       <= ini_clr_d;
            ack_seen_q      <= ack_seen_d;
            pending_q       <= pending_d;
            boot_q          <= 1'b0;
            rsp_iso_q       <= rsp_iso_d;
            rsp_clr_q       <= rsp_clr_d;
            async_req_o     <= req_d;
            async_phase_o   <= phase_d;
            async_ack_o     <= ack_d;
            isolate_o       <= ini_iso_d | rsp_iso_d;
            clear_o         <= ini_clr_d | rsp_clr_d;
            clear_pending_o <= (ini_state_d != INI_IDLE) | rsp_iso_d;
        end
    end

    a_phase_never_none : assert property (@(posedge clk_i) disable iff (rst_i)
        (async_req_o != $past(async_req_o)) |-> (async_phase_o != PH_NONE));
    a_phase_with_req : assert property (@(posedge clk_i) disable iff (rst_i)
        (async_phase_o != $past(async_phase_o)) |-> (async_req_o != $past(async_req_o)));

endmodule

// File: tb/tb_cdc_clear_sequencer.sv
// Directed bench: two sequencer halves on 10 ns and 37 ns clocks, acks modelled as isolate/clear delayed one cycle.
`timescale 1ns / 100ps

module tb_cdc_clear_sequencer;

    typedef struct {
        bit a_clr;
        bit b_clr;
        bit overlap;
        bit b_iso_early;
        int rises;
        int low_len;
    } obs_t;

    logic       clk_a = 1'b0;
    logic       clk_b = 1'b0;
    logic       rst_a, rst_b;
    logic       clear_a, clear_b;
    logic       hold_iso_a;
    logic       pend_a, iso_a, clr_a, req_a, ack_a;
    logic       pend_b, iso_b, clr_b, req_b, ack_b;
    logic [1:0] phase_a, phase_b;
    logic       iso_dly_a, clr_dly_a, iso_dly_b, clr_dly_b;
    logic       iso_ack_a, clr_ack_a, iso_ack_b, clr_ack_b;

    int errors = 0;
    int checks = 0;
    int req_tog_a = 0, req_tog_b = 0, ack_tog_a = 0, ack_tog_b = 0;

    always #5 clk_a = ~clk_a;
    always #18.5 clk_b = ~clk_b;

    cdc_clear_sequencer #(.SYNC_STAGES(2), .CLEAR_ON_ASYNC_RESET(1'b1)) u_a (
        .clk_i(clk_a), .rst_i(rst_a), .clear_i(clear_a), .clear_pending_o(pend_a),
        .isolate_o(iso_a), .isolate_ack_i(iso_ack_a), .clear_o(clr_a), .clear_ack_i(clr_ack_a),
        .async_req_o(req_a), .async_phase_o(phase_a), .async_ack_i(ack_b),
        .async_req_i(req_b), .async_phase_i(phase_b), .async_ack_o(ack_a)
    );

    cdc_clear_sequencer #(.SYNC_STAGES(2), .CLEAR_ON_ASYNC_RESET(1'b1)) u_b (
        .clk_i(clk_b), .rst_i(rst_b), .clear_i(clear_b), .clear_pending_o(pend_b),
        .isolate_o(iso_b), .isolate_ack_i(iso_ack_b), .clear_o(clr_b), .clear_ack_i(clr_ack_b),
        .async_req_o(req_b), .async_phase_o(phase_b), .async_ack_i(ack_a),
        .async_req_i(req_a), .async_phase_i(phase_a), .async_ack_o(ack_b)
    );

    always @(posedge clk_a or posedge rst_a) begin
        if (rst_a) begin
            iso_dly_a <= 1'b0;
            clr_dly_a <= 1'b0;
        end else begin
            iso_dly_a <= iso_a;
            clr_dly_a <= clr_a;
        end
    end

    always @(posedge clk_b or posedge rst_b) begin
        if (rst_b) begin
            iso_dly_b <= 1'b0;
            clr_dly_b <= 1'b0;
        end else begin
            iso_dly_b <= iso_b;
            clr_dly_b <= clr_b;
        end
    end

    assign iso_ack_a = iso_dly_a & ~hold_iso_a;
    assign clr_ack_a = clr_dly_a;
    assign iso_ack_b = iso_dly_b;
    assign clr_ack_b = clr_dly_b;

    always @(posedge req_a or negedge req_a) req_tog_a <= req_tog_a + 1;
    always @(posedge req_b or negedge req_b) req_tog_b <= req_tog_b + 1;
    always @(posedge ack_a or negedge ack_a) ack_tog_a <= ack_tog_a + 1;
    always @(posedge ack_b or negedge ack_b) ack_tog_b <= ack_tog_b + 1;

    task automatic a_cycle();
        @(posedge clk_a);
        #1;
    endtask

    task automatic a_cycles(input int n);
        for (int i = 0; i < n; i++) a_cycle();
    endtask

    task automatic pulse_clear_a();
        clear_a = 1'b1;
        a_cycle();
        clear_a = 1'b0;
    endtask

    // Samples both halves every A cycle until both report idle for 10 cycles in a row.
    task automatic observe(input int budget, output bit ok, output obs_t o);
        int  idle_run;
        int  low;
        bit  prev_iso;
        o.a_clr = 0; o.b_clr = 0; o.overlap = 0; o.b_iso_early = 0; o.rises = 0; o.low_len = 0;
        ok = 1'b0;
        idle_run = 0;
        low = 0;
        prev_iso = iso_a;
        for (int i = 0; i < budget; i++) begin
            a_cycle();
            if (clr_a) o.a_clr = 1;
            if (clr_b) o.b_clr = 1;
            if (clr_a && clr_b) o.overlap = 1;
            if (iso_b && !o.a_clr && !o.b_clr) o.b_iso_early = 1;
            if (!iso_a) low++;
            else begin
                if (!prev_iso) begin
                    o.rises++;
                    o.low_len = low;
                end
                low = 0;
            end
            prev_iso = iso_a;
            if (!pend_a && !pend_b) idle_run++;
            else idle_run = 0;
            if (idle_run >= 10) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int   base;
        bit   ok;
        obs_t o;
        #20;
        checks++;
        if ({pend_a, iso_a, clr_a, req_a, phase_a, ack_a} !== 7'b0) begin
            errors++;
            $display("FAIL reset_a_outputs: got %b expected 0000000", {pend_a, iso_a, clr_a, req_a, phase_a, ack_a});
        end
        checks++;
        if ({pend_b, iso_b, clr_b, req_b, phase_b, ack_b} !== 7'b0) begin
            errors++;
            $display("FAIL reset_b_outputs: got %b expected 0000000", {pend_b, iso_b, clr_b, req_b, phase_b, ack_b});
        end
        a_cycles(3);
        base = req_tog_a;
        rst_a = 1'b0;
        rst_b = 1'b0;
        a_cycle();
        checks++;
        if ({iso_a, phase_a, req_a} !== 4'b1011) begin
            errors++;
            $display("FAIL boot_restart_iso: got iso/phase/req=%b expected 1011", {iso_a, phase_a, req_a});
        end
        observe(400, ok, o);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL boot_idle: got idle=%0b expected 1", ok);
        end
        checks++;
        if (req_tog_a - base !== 3) begin
            errors++;
            $display("FAIL boot_req_toggles: got %0d expected 3", req_tog_a - base);
        end
        checks++;
        if ({iso_a, clr_a, iso_b, clr_b} !== 4'b0) begin
            errors++;
            $display("FAIL boot_quiet: got %b expected 0000", {iso_a, clr_a, iso_b, clr_b});
        end
    endtask

    task automatic test_basic();
        int   base;
        bit   ok;
        obs_t o;
        base = req_tog_a;
        a_cycles(5);
        pulse_clear_a();
        checks++;
        if ({iso_a, phase_a, pend_a} !== 4'b1011 || req_tog_a - base !== 1) begin
            errors++;
            $display("FAIL basic_iso_latency: got iso/phase/pend=%b toggles=%0d expected 1011 toggles=1",
                     {iso_a, phase_a, pend_a}, req_tog_a - base);
        end
        observe(400, ok, o);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle: got idle=%0b expected 1", ok);
        end
        checks++;
        if (o.b_iso_early !== 1'b1 || o.overlap !== 1'b1) begin
            errors++;
            $display("FAIL basic_order: got b_iso_first=%0b clear_overlap=%0b expected 1 1", o.b_iso_early, o.overlap);
        end
        checks++;
        if (req_tog_a - base !== 3) begin
            errors++;
            $display("FAIL basic_req_toggles: got %0d expected 3", req_tog_a - base);
        end
        checks++;
        if ({iso_a, iso_b, clr_a, clr_b, pend_a} !== 5'b0) begin
            errors++;
            $display("FAIL basic_end_state: got %b expected 00000", {iso_a, iso_b, clr_a, clr_b, pend_a});
        end
    endtask

    task automatic test_hold_isolate_ack();
        int   base_ack;
        int   base_req;
        int   bad;
        bit   seen;
        bit   ok;
        obs_t o;
        base_ack = ack_tog_b;
        base_req = req_tog_a;
        hold_iso_a = 1'b1;
        a_cycles(2);
        pulse_clear_a();
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ack_tog_b != base_ack) begin
                seen = 1'b1;
                break;
            end
            a_cycle();
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL hold_peer_ack: got ack_seen=%0b expected 1", seen);
        end
        a_cycles(4);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            a_cycle();
            if ({iso_a, clr_a, phase_a} !== 4'b1001) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stays_iso: got %0d bad cycles expected 0", bad);
        end
        hold_iso_a = 1'b0;
        a_cycle();
        checks++;
        if ({clr_a, phase_a} !== 3'b110) begin
            errors++;
            $display("FAIL hold_release_clr: got clear/phase=%b expected 110", {clr_a, phase_a});
        end
        observe(400, ok, o);
        checks++;
        if (ok !== 1'b1 || req_tog_a - base_req !== 3) begin
            errors++;
            $display("FAIL hold_finish: got idle=%0b toggles=%0d expected 1 3", ok, req_tog_a - base_req);
        end
    endtask

    task automatic test_simultaneous();
        int   ba, bb, ra, rb;
        bit   ok;
        obs_t o;
        ba = ack_tog_a; bb = ack_tog_b; ra = req_tog_a; rb = req_tog_b;
        a_cycles(3);
        clear_a = 1'b1;
        clear_b = 1'b1;
        fork
            begin @(posedge clk_a); #1; clear_a = 1'b0; end
            begin @(posedge clk_b); #1; clear_b = 1'b0; end
        join
        observe(200, ok, o);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL simul_no_hang: got idle=%0b expected 1", ok);
        end
        checks++;
        if (o.a_clr !== 1'b1 || o.b_clr !== 1'b1) begin
            errors++;
            $display("FAIL simul_clear_seen: got a=%0b b=%0b expected 1 1", o.a_clr, o.b_clr);
        end
        checks++;
        if (ack_tog_a - ba !== 3 || ack_tog_b - bb !== 3) begin
            errors++;
            $display("FAIL simul_ack_toggles: got a=%0d b=%0d expected 3 3", ack_tog_a - ba, ack_tog_b - bb);
        end
        checks++;
        if (req_tog_a - ra !== 3 || req_tog_b - rb !== 3) begin
            errors++;
            $display("FAIL simul_req_toggles: got a=%0d b=%0d expected 3 3", req_tog_a - ra, req_tog_b - rb);
        end
    endtask

    task automatic test_back_to_back();
        int   base;
        bit   ok;
        obs_t o;
        base = req_tog_a;
        a_cycles(5);
        pulse_clear_a();
        a_cycles(2);
        pulse_clear_a();
        observe(400, ok, o);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: got idle=%0b expected 1", ok);
        end
        checks++;
        if (o.rises !== 1 || o.low_len !== 1) begin
            errors++;
            $display("FAIL b2b_restart_gap: got rises=%0d gap=%0d expected 1 1", o.rises, o.low_len);
        end
        checks++;
        if (req_tog_a - base !== 6) begin
            errors++;
            $display("FAIL b2b_req_toggles: got %0d expected 6", req_tog_a - base);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit   seen;
        bit   ok;
        obs_t o;
        a_cycles(3);
        pulse_clear_a();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (clr_a) begin
                seen = 1'b1;
                break;
            end
            a_cycle();
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL midclr_reach_clr: got %0b expected 1", seen);
        end
        a_cycles(2);
        rst_a = 1'b1;
        #1;
        checks++;
        if ({pend_a, iso_a, clr_a, req_a, phase_a, ack_a} !== 7'b0) begin
            errors++;
            $display("FAIL midclr_reset_outputs: got %b expected 0000000", {pend_a, iso_a, clr_a, req_a, phase_a, ack_a});
        end
        a_cycles(50);
        rst_a = 1'b0;
        a_cycle();
        checks++;
        if ({iso_a, phase_a, req_a} !== 4'b1011) begin
            errors++;
            $display("FAIL midclr_restart: got iso/phase/req=%b expected 1011", {iso_a, phase_a, req_a});
        end
        observe(400, ok, o);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL midclr_idle: got idle=%0b expected 1", ok);
        end
        checks++;
        if ({pend_a, pend_b, iso_a, iso_b, clr_a, clr_b} !== 6'b0) begin
            errors++;
            $display("FAIL midclr_end_state: got %b expected 000000", {pend_a, pend_b, iso_a, iso_b, clr_a, clr_b});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        clear_a = 1'b0;
        clear_b = 1'b0;
        hold_iso_a = 1'b0;
        test_reset();
        test_basic();
        test_hold_isolate_ack();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
